object2_renderer: RTL and testbench
===================================

Name: object2_renderer

Overview:
- Stage directly upstream of the 2x2 sprite ROM for object 2.
- Owns object 2's screen position and bounce motion.
- Converts the VGA pixel x/y into ROM row/col addresses and consumes the ROM's 12-bit color_data.
- Produces the pipelined, transparency-keyed pixel that goes to the frame mux, aligned to a delayed background pixel.

Parameters:
- ROW_W, 1, ROM row address width; sprite has 2^ROW_W texel rows.
- COL_W, 1, ROM column address width; sprite has 2^COL_W texel columns.
- SCALE_LOG2, 3, each texel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels; object is 16x16 at defaults.
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- INIT_X, 100, reset x position (left edge).
- INIT_Y, 50, reset y position (top edge).
- SPEED, 2, pixels moved per frame_tick on each axis.
- KEY_COLOR, 12'h000, transparent color.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- video_on  in  1  pixel is in the visible area.
- bg_rgb  in  12  background pixel for the same x/y.
- frame_tick  in  1  one-cycle pulse, once per frame, during vblank.
- move_en  in  1  enables motion updates on frame_tick.
- other_on  in  1  other object's opaque flag, aligned with rgb_out (used only with the option).
- color_data  in  12  sprite ROM output.
- rom_row  out  ROW_W  sprite ROM row address.
- rom_col  out  COL_W  sprite ROM column address.
- rgb_out  out  12  composited pixel.
- obj_on  out  1  object 2 opaque at rgb_out's pixel.
- pos_x  out  10  current x position.
- pos_y  out  10  current y position.
- collide  out  1  sticky collision flag.

Behaviour:
- Clocking and reset: a single clk domain. reset_n is asynchronous and active-low.
- Reset values:
  - pos_x = INIT_X, pos_y = INIT_Y.
  - dir_x = +, dir_y = +.
  - All pipeline registers 0, so rgb_out = 0, obj_on = 0, collide = 0.
- Reset priority: reset asserted mid-frame or mid-tick wins over everything. The first valid output appears 2 cycles after release.
- Object size: OBJ_W = 2^(COL_W+SCALE_LOG2), OBJ_H = 2^(ROW_W+SCALE_LOG2).
- Stage 0 (combinational from x/y and position registers):
  - Use 11-bit unsigned compares.
  - in_box = (x >= pos_x) && (x < pos_x+OBJ_W) && (y >= pos_y) && (y < pos_y+OBJ_H).
  - rom_col = (x - pos_x) >> SCALE_LOG2, truncated to COL_W.
  - rom_row = (y - pos_y) >> SCALE_LOG2, truncated to ROW_W.
  - When in_box = 0, rom_row and rom_col are don't-care.
- ROM timing: the ROM registers its address, so color_data corresponds to the previous cycle's rom_row/rom_col.
- Stage 1 (registered): d1_in, d1_vid and d1_bg capture in_box, video_on and bg_rgb.
- Stage 2 (registered):
  - opaque = d1_in && d1_vid && (color_data != KEY_COLOR).
  - rgb_out = opaque ? color_data : (d1_vid ? d1_bg : 0).
  - obj_on = opaque.
- Latency: x/y in cycle t produces rgb_out and obj_on valid after edge t+2. The pipeline runs every cycle, with no stalls.
- Motion is evaluated only on a frame_tick && move_en cycle; otherwise position and direction hold. Per axis, with MAX = H_RES-OBJ_W for x and V_RES-OBJ_H for y:
  - dir + and pos+SPEED >= MAX: pos = MAX, dir flips to -.
  - dir + otherwise: pos += SPEED.
  - dir - and pos <= SPEED: pos = 0, dir flips to +.
  - dir - otherwise: pos -= SPEED.
- Position update timing: a position update takes effect on the tick edge. Because ticks occur in vblank, a visible frame never sees a position change.
- pos_x and pos_y are driven directly from the registers.
- Boundary: a position exactly at 0 or MAX with the direction pointing outward flips direction and stays at the clamp value.

Optional Feature:
- Macro: OBJ2_COLLIDE_EN.
- Defined:
  - collide is set when obj_on && other_on in the same cycle, and is sticky.
  - On frame_tick, collide is cleared.
  - Set has priority over clear on the same cycle.
- Undefined: collide is tied to 0 and other_on is ignored.

Test Plan:
- Reset → pos = (100,50), rgb_out = 0, obj_on = 0.
  - Then drive x=100, y=50, video_on=1, color_data=12'hFFF: rom_row=0 and rom_col=0 in the same cycle; rgb_out = 12'hFFF and obj_on = 1 two cycles later.
- x=108, y=58 → rom_row=1, rom_col=1. x=116 → in_box=0, so rgb_out = bg_rgb (e.g. 12'h0F0) after 2 cycles.
- color_data = 12'h000 inside the box → rgb_out = bg_rgb and obj_on = 0 (transparency).
- Bounce: move_en=1, pos_x forced via ticks to 622 with dir + → the next tick gives pos_x = 624 (MAX) and dir -; the following tick gives 622.
  - With dir -, pos_y=1 → the tick gives pos_y = 0 and dir +.
- frame_tick with move_en=0 → position unchanged.
  - reset_n dropped mid-frame → outputs 0 immediately and position returns to (100,50).
- With OBJ2_COLLIDE_EN:
  - obj_on=1 and other_on=1 → collide=1 on the next edge; it holds until frame_tick, then returns to 0.
  - Simultaneous set and tick → collide stays 1.

Source files
------------

// File: rtl/object2_renderer.sv
// Object 2 sprite renderer: bounce motion, ROM addressing, transparency-keyed composite over background.
// Latency: x/y presented in cycle t yields rgb_out/obj_on after edge t+2; position updates on frame_tick edges.
// Backpressure: none; the pipeline advances every cycle. Optional collision flag enabled by OBJ2_COLLIDE_EN.
module object2_renderer #(
    parameter int          ROW_W      = 1,
    parameter int          COL_W      = 1,
    parameter int          SCALE_LOG2 = 3,
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          INIT_X     = 100,
    parameter int          INIT_Y     = 50,
    parameter int          SPEED      = 2,
    parameter logic [11:0] KEY_COLOR  = 12'h000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             video_on,
    input  logic [11:0]      bg_rgb,
    input  logic             frame_tick,
    input  logic             move_en,
    input  logic             other_on,
    input  logic [11:0]      color_data,
    output logic [ROW_W-1:0] rom_row,
    output logic [COL_W-1:0] rom_col,
    output logic [11:0]      rgb_out,
    output logic             obj_on,
    output logic [9:0]       pos_x,
    output logic [9:0]       pos_y,
    output logic             collide
);

    localparam int          OBJ_W  = 1 << (COL_W + SCALE_LOG2);
    localparam int          OBJ_H  = 1 << (ROW_W + SCALE_LOG2);
    localparam logic [10:0] OBJ_W11 = 11'(OBJ_W);
    localparam logic [10:0] OBJ_H11 = 11'(OBJ_H);
    localparam logic [10:0] MAX_X  = 11'(H_RES - OBJ_W);
    localparam logic [10:0] MAX_Y  = 11'(V_RES - OBJ_H);
    localparam logic [10:0] SPD11  = 11'(SPEED);
    localparam logic [9:0]  SPD10  = 10'(SPEED);
    localparam logic [9:0]  INIT_X10 = 10'(INIT_X);
    localparam logic [9:0]  INIT_Y10 = 10'(INIT_Y);

    // Position and direction state; dir = 1 means moving toward larger coordinates.
    logic [9:0] pos_x_q;
    logic [9:0] pos_y_q;
    logic       dir_x;
    logic       dir_y;

    // Stage 0: box test and texel offsets, all in 11 bits so pos+OBJ_W cannot wrap.
    logic [10:0] x_e;
    logic [10:0] y_e;
    logic [10:0] px_e;
    logic [10:0] py_e;
    logic [10:0] off_x;
    logic [10:0] off_y;
    logic        in_box;

    assign x_e   = {1'b0, x};
    assign y_e   = {1'b0, y};
    assign px_e  = {1'b0, pos_x_q};
    assign py_e  = {1'b0, pos_y_q};
    assign off_x = x_e - px_e;
    assign off_y = y_e - py_e;

    assign in_box = (x_e >= px_e) && (x_e < px_e + OBJ_W11) &&
                    (y_e >= py_e) && (y_e < py_e + OBJ_H11);

    // Offset divided by texel size, truncated to the ROM address width.
    assign rom_col = off_x[SCALE_LOG2 +: COL_W];
    assign rom_row = off_y[SCALE_LOG2 +: ROW_W];

    // Only the texel-index bits of the offsets feed the ROM; the rest are intentionally dropped.
    logic unused_off_bits;
    assign unused_off_bits = ^{off_x, off_y};

    // Stage 1 registers, aligned with the ROM's registered address.
    logic        d1_in;
    logic        d1_vid;
    logic [11:0] d1_bg;

    // Stage 1: capture box, blanking and background alongside the ROM lookup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_in  <= 1'b0;
            d1_vid <= 1'b0;
            d1_bg  <= 12'h000;
        end else begin
            d1_in  <= in_box;
            d1_vid <= video_on;
            d1_bg  <= bg_rgb;
        end
    end

    logic opaque;
    assign opaque = d1_in && d1_vid && (color_data != KEY_COLOR);

    // Stage 2: key out transparent texels and fall back to background (or black in blanking).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out <= 12'h000;
            obj_on  <= 1'b0;
        end else begin
            rgb_out <= opaque ? color_data : (d1_vid ? d1_bg : 12'h000);
            obj_on  <= opaque;
        end
    end

    // Bounce motion: step by SPEED per enabled tick, clamp at the edge and reverse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q <= INIT_X10;
            pos_y_q <= INIT_Y10;
            dir_x   <= 1'b1;
            dir_y   <= 1'b1;
        end else if (frame_tick && move_en) begin
            if (dir_x) begin
                if (px_e + SPD11 >= MAX_X) begin
                    pos_x_q <= MAX_X[9:0];
                    dir_x   <= 1'b0;
                end else begin
                    pos_x_q <= pos_x_q + SPD10;
                end
            end else begin
                if (px_e <= SPD11) begin
                    pos_x_q <= 10'd0;
                    dir_x   <= 1'b1;
                end else begin
                    pos_x_q <= pos_x_q - SPD10;
                end
            end

            if (dir_y) begin
                if (py_e + SPD11 >= MAX_Y) begin
                    pos_y_q <= MAX_Y[9:0];
                    dir_y   <= 1'b0;
                end else begin
                    pos_y_q <= pos_y_q + SPD10;
                end
            end else begin
                if (py_e <= SPD11) begin
                    pos_y_q <= 10'd0;
                    dir_y   <= 1'b1;
                end else begin
                    pos_y_q <= pos_y_q - SPD10;
                end
            end
        end
    end

    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;

`ifdef OBJ2_COLLIDE_EN
    // Sticky overlap flag, cleared once per frame; a fresh overlap beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collide <= 1'b0;
        end else if (obj_on && other_on) begin
            collide <= 1'b1;
        end else if (frame_tick) begin
            collide <= 1'b0;
        end
    end
`else
    // Collision tracking compiled out; the other object's flag has no effect.
    logic unused_other_on;
    assign unused_other_on = other_on;
    assign collide         = 1'b0;
`endif

endmodule

// File: tb/tb_object2_renderer.sv
module tb_object2_renderer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic [11:0] bg_rgb;
    logic        frame_tick;
    logic        move_en;
    logic        other_on;
    logic [11:0] color_data;
    logic [0:0]  rom_row;
    logic [0:0]  rom_col;
    logic [11:0] rgb_out;
    logic        obj_on;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        collide;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        on;
        string       name;
    } exp_t;
    exp_t sb[$];

    // Sprite texels indexed by {row, col}; texel (0,1) is the key color.
    logic [11:0] rom [4];
    initial begin
        rom[0] = 12'hFFF;
        rom[1] = 12'h000;
        rom[2] = 12'hF00;
        rom[3] = 12'h00F;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read ROM model: data follows the previous cycle's address.
    always @(posedge clk) color_data <= rom[{rom_row, rom_col}];

    object2_renderer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .bg_rgb     (bg_rgb),
        .frame_tick (frame_tick),
        .move_en    (move_en),
        .other_on   (other_on),
        .color_data (color_data),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rgb_out    (rgb_out),
        .obj_on     (obj_on),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .collide    (collide)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare output pixel against the entry due this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_rgb"}, {20'd0, rgb_out}, {20'd0, e.rgb});
            check({e.name, "_on"}, {31'd0, obj_on}, {31'd0, e.on});
        end
    end

    // Drive one pixel; optionally check ROM address combinationally in the same cycle.
    task automatic send(input string name, input int px, input int py, input logic vid,
                        input logic [11:0] bg, input logic [11:0] ergb, input logic eon,
                        input bit chk_rom, input int erow, input int ecol);
        exp_t e;
        @(posedge clk);
        #1;
        x        = 10'(px);
        y        = 10'(py);
        video_on = vid;
        bg_rgb   = bg;
        e.due    = cyc + 2;
        e.rgb    = ergb;
        e.on     = eon;
        e.name   = name;
        sb.push_back(e);
        if (chk_rom) begin
            #1;
            check({name, "_row"}, {31'd0, rom_row}, 32'(erow));
            check({name, "_col"}, {31'd0, rom_col}, 32'(ecol));
        end
    endtask

    task automatic ticks(input int n, input logic en);
        repeat (n) begin
            @(posedge clk);
            #1;
            frame_tick = 1'b1;
            move_en    = en;
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
            move_en    = 1'b0;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        x          = 10'd0;
        y          = 10'd0;
        video_on   = 1'b0;
        bg_rgb     = 12'h000;
        frame_tick = 1'b0;
        move_en    = 1'b0;
        other_on   = 1'b0;
        #12;
        check("rst_pos_x", 32'(pos_x), 32'd100);
        check("rst_pos_y", 32'(pos_y), 32'd50);
        check("rst_rgb", 32'(rgb_out), 32'h0);
        check("rst_on", 32'(obj_on), 32'd0);
        check("rst_collide", 32'(collide), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed pixels against the sprite at (100,50), 16x16, 8x8 texels.
        send("v_tl",     100, 50, 1'b1, 12'h0F0, 12'hFFF, 1'b1, 1, 0, 0);
        send("v_br_tex", 108, 58, 1'b1, 12'h0F0, 12'h00F, 1'b1, 1, 1, 1);
        send("v_right",  116, 58, 1'b1, 12'h0F0, 12'h0F0, 1'b0, 0, 0, 0);
        send("v_key",    108, 50, 1'b1, 12'h123, 12'h123, 1'b0, 1, 0, 1);
        send("v_bl_tex", 100, 58, 1'b1, 12'h0F0, 12'hF00, 1'b1, 1, 1, 0);
        send("v_left",    99, 50, 1'b1, 12'h456, 12'h456, 1'b0, 0, 0, 0);
        send("v_corner", 115, 65, 1'b1, 12'h0F0, 12'h00F, 1'b1, 1, 1, 1);
        send("v_below",  100, 66, 1'b1, 12'h789, 12'h789, 1'b0, 0, 0, 0);
        send("v_blank_in", 100, 50, 1'b0, 12'h0F0, 12'h000, 1'b0, 0, 0, 0);
        send("v_blank_out", 300, 300, 1'b0, 12'h0F0, 12'h000, 1'b0, 0, 0, 0);
        drain();

        // Collision flag behaviour; pixel (100,50) held keeps obj_on high.
        send("c_px", 100, 50, 1'b1, 12'h0F0, 12'hFFF, 1'b1, 0, 0, 0);
        drain();
`ifdef OBJ2_COLLIDE_EN
        other_on = 1'b1;
        @(posedge clk);
        #1;
        other_on = 1'b0;
        check("col_set", 32'(collide), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("col_hold", 32'(collide), 32'd1);
        ticks(1, 1'b0);
        check("col_clear", 32'(collide), 32'd0);
        @(posedge clk);
        #1;
        other_on   = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        other_on   = 1'b0;
        frame_tick = 1'b0;
        check("col_set_beats_clear", 32'(collide), 32'd1);
`else
        other_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        other_on = 1'b0;
        check("col_disabled", 32'(collide), 32'd0);
`endif

        // Tick without move_en holds position.
        ticks(3, 1'b0);
        check("hold_x", 32'(pos_x), 32'd100);
        check("hold_y", 32'(pos_y), 32'd50);

        // 261 ticks: x 100->622; y hits 464 at tick 207 then falls to 356.
        ticks(261, 1'b1);
        check("mv261_x", 32'(pos_x), 32'd622);
        check("mv261_y", 32'(pos_y), 32'd356);
        ticks(1, 1'b1);
        check("clamp_x_max", 32'(pos_x), 32'd624);
        check("mv262_y", 32'(pos_y), 32'd354);
        ticks(1, 1'b1);
        check("bounce_x", 32'(pos_x), 32'd622);
        check("mv263_y", 32'(pos_y), 32'd352);
        ticks(175, 1'b1);
        check("mv438_y", 32'(pos_y), 32'd2);
        ticks(1, 1'b1);
        check("clamp_y_zero", 32'(pos_y), 32'd0);
        check("mv439_x", 32'(pos_x), 32'd270);
        ticks(1, 1'b1);
        check("bounce_y", 32'(pos_y), 32'd2);
        check("mv440_x", 32'(pos_x), 32'd268);

        // Sprite moved: probe a pixel inside it at its new place.
        send("v_moved", 268, 2, 1'b1, 12'h0F0, 12'hFFF, 1'b1, 1, 0, 0);
        drain();

        // Mid-frame reset with a non-zero background on screen.
        @(posedge clk);
        #1;
        x        = 10'd0;
        y        = 10'd100;
        video_on = 1'b1;
        bg_rgb   = 12'hABC;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_rgb", 32'(rgb_out), 32'hABC);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_rgb", 32'(rgb_out), 32'h0);
        check("mid_rst_on", 32'(obj_on), 32'd0);
        check("mid_rst_x", 32'(pos_x), 32'd100);
        check("mid_rst_y", 32'(pos_y), 32'd50);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        send("v_after_rst", 100, 50, 1'b1, 12'h0F0, 12'hFFF, 1'b1, 1, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout reached expected=finish");
        $fatal(1);
    end

endmodule
